// File: rtl/flash_pkt_streamer_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : flash_pkt_streamer_pkg                                        |
// | Brief   : Shared types and constants for the flash packet streamer:     |
// |           FSM state encoding, default geometry, flash opcodes, helpers. |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

package flash_pkt_streamer_pkg;

  // Streamer control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHUNK  = 2'd1,
    ST_STREAM = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  // Default geometry
  localparam int c_page_bytes_def  = 256;
  localparam int c_depth_words_def = 512;

  // Opcodes issued by the downstream page-program driver
  localparam logic [7:0] c_op_wren = 8'h06;
  localparam logic [7:0] c_op_pp   = 8'h02;

  // Unsigned 16-bit minimum
  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

  // Extract one byte of a word, lane 0 = [31:24] (MSB first)
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/flash_pkt_wbuf.sv
// ---------------------------------------------------------------------------
// | Module  : flash_pkt_wbuf                                                |
// | Brief   : Single-clock word buffer with write/read pointers and a word  |
// |           count. rd_data shows the word at the read pointer; rd_en pops.|
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module flash_pkt_wbuf #(
  parameter int DEPTH_WORDS = 512
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [31:0]                    wr_data,
  input  logic                           rd_en,
  input  logic                           clr,
  output logic [31:0]                    rd_data,
  output logic [$clog2(DEPTH_WORDS):0]   count,
  output logic                           full
);

  localparam int             c_aw    = $clog2(DEPTH_WORDS);
  localparam logic [c_aw:0]  c_depth = (c_aw + 1)'(DEPTH_WORDS);

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [c_aw-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_aw:0]   count_q;
  logic            w_do_wr, w_do_rd;

  // A write into a full buffer is silently dropped; clear beats everything
  assign full    = (count_q == c_depth);
  assign w_do_wr = wr_en & ~full & ~clr;
  assign w_do_rd = rd_en & (count_q != '0) & ~clr;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage array, no reset needed: validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (w_do_wr && !w_do_rd)      count_q <= count_q + 1'b1;
      else if (!w_do_wr && w_do_rd) count_q <= count_q - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/flash_pkt_streamer.sv
// ---------------------------------------------------------------------------
// | Module  : flash_pkt_streamer                                            |
// | Brief   : Buffers one UDP packet as words, unpacks it MSB-first into    |
// |           bytes and hands it to the SPI flash page-program driver as    |
// |           page-aligned chunks, advancing a 24-bit write address.        |
// |           Optional macro FLASH_PKT_STREAMER_STAT_EN adds the pkt_cnt /  |
// |           drop_cnt saturating statistics outputs.                       |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module flash_pkt_streamer
  import flash_pkt_streamer_pkg::*;
#(
  parameter int DEPTH_WORDS = c_depth_words_def,
  parameter int PAGE_BYTES  = c_page_bytes_def
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        pkt_done,
  input  logic [15:0] pkt_byte_num,
  input  logic        addr_load,
  input  logic [23:0] base_addr,
  output logic        prog_start,
  output logic [23:0] prog_addr,
  output logic [8:0]  prog_len,
  input  logic        byte_req,
  output logic [7:0]  byte_data,
  input  logic        prog_done,
  output logic        busy,
  output logic        overflow
`ifdef FLASH_PKT_STREAMER_STAT_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int c_aw = $clog2(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic [23:0] addr_q,  addr_d;
  logic [15:0] rem_q,   rem_d;
  logic [8:0]  sent_q,  sent_d;
  logic [1:0]  lane_q,  lane_d;
  logic [31:0] word_q,  word_d;
  logic [7:0]  byte_q,  byte_d;
  logic        start_q, start_d;
  logic [23:0] paddr_q, paddr_d;
  logic [8:0]  plen_q,  plen_d;
  logic        ovf_q,   ovf_d;

  logic          w_buf_wr, w_buf_rd, w_buf_clr, w_buf_full, w_ovf_evt;
  logic [31:0]   w_buf_data;
  logic [c_aw:0] w_buf_count;
  logic [15:0]   w_words, w_len, w_room, w_chunk, w_rem_next;

  flash_pkt_wbuf #(.DEPTH_WORDS(DEPTH_WORDS)) u_wbuf (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .wr_en   (w_buf_wr),
    .wr_data (wr_data),
    .rd_en   (w_buf_rd),
    .clr     (w_buf_clr),
    .rd_data (w_buf_data),
    .count   (w_buf_count),
    .full    (w_buf_full)
  );

  // A word written in the same cycle as pkt_done is counted in the length
  assign w_words    = 16'(w_buf_count) + {15'd0, wr_en & ~w_buf_full};
  assign w_len      = min16(pkt_byte_num, w_words << 2);
  assign w_room     = 16'(PAGE_BYTES) - 16'(addr_q & 24'(PAGE_BYTES - 1));
  assign w_chunk    = min16(rem_q, w_room);
  assign w_rem_next = rem_q - {7'd0, plen_q};

  // Next-state, datapath and buffer control
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    sent_d    = sent_q;
    lane_d    = lane_q;
    word_d    = word_q;
    byte_d    = byte_q;
    start_d   = 1'b0;
    paddr_d   = paddr_q;
    plen_d    = plen_q;
    ovf_d     = ovf_q;
    w_buf_wr  = 1'b0;
    w_buf_rd  = 1'b0;
    w_buf_clr = 1'b0;
    w_ovf_evt = 1'b0;

    case (state_q)
      ST_IDLE: begin
        w_buf_wr  = wr_en;
        w_ovf_evt = wr_en & w_buf_full;
        if (addr_load) begin
          addr_d = base_addr;
          ovf_d  = 1'b0;
        end
        if (pkt_done) begin
          if (w_len == 16'd0) begin
            w_buf_clr = 1'b1;
          end else begin
            rem_d   = w_len;
            lane_d  = 2'd0;
            state_d = ST_CHUNK;
          end
        end
      end

      ST_CHUNK: begin
        plen_d  = 9'(w_chunk);
        paddr_d = addr_q;
        start_d = 1'b1;
        sent_d  = 9'd0;
        state_d = ST_STREAM;
      end

      ST_STREAM: begin
        w_ovf_evt = wr_en | pkt_done;
        if (byte_req) begin
          // Fetch a fresh word whenever its leading byte is due
          if (lane_q == 2'd0) begin
            w_buf_rd = 1'b1;
            word_d   = w_buf_data;
            byte_d   = w_buf_data[31:24];
          end else begin
            byte_d   = word_byte(word_q, lane_q);
          end
          lane_d = lane_q + 2'd1;
          sent_d = sent_q + 9'd1;
          if (sent_d == plen_q) state_d = ST_WAIT;
        end
      end

      default: begin // ST_WAIT
        w_ovf_evt = wr_en | pkt_done;
        if (prog_done) begin
          addr_d = addr_q + {15'd0, plen_q};
          rem_d  = w_rem_next;
          if (w_rem_next != 16'd0) begin
            state_d = ST_CHUNK;
          end else begin
            w_buf_clr = 1'b1;
            lane_d    = 2'd0;
            state_d   = ST_IDLE;
          end
        end
      end
    endcase

    ovf_d = ovf_d | w_ovf_evt;
  end

  // State and datapath registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      sent_q  <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      start_q <= 1'b0;
      paddr_q <= '0;
      plen_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      sent_q  <= sent_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      start_q <= start_d;
      paddr_q <= paddr_d;
      plen_q  <= plen_d;
      ovf_q   <= ovf_d;
    end
  end

  assign prog_start = start_q;
  assign prog_addr  = paddr_q;
  assign prog_len   = plen_q;
  assign byte_data  = byte_q;
  assign busy       = (state_q != ST_IDLE);
  assign overflow   = ovf_q;

`ifdef FLASH_PKT_STREAMER_STAT_EN
  logic [15:0] pkt_cnt_q, drop_cnt_q;
  logic        w_pkt_fin;

  assign w_pkt_fin = (state_q == ST_WAIT) & prog_done & (w_rem_next == 16'd0);

  // Saturating packet / drop statistics, untouched by addr_load
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (w_pkt_fin && pkt_cnt_q != 16'hFFFF)  pkt_cnt_q  <= pkt_cnt_q + 16'd1;
      if (w_ovf_evt && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_flash_pkt_streamer.sv
// ---------------------------------------------------------------------------
// | Module  : tb_flash_pkt_streamer                                         |
// | Brief   : Self-checking bench for flash_pkt_streamer: directed packets  |
// |           plus random packets against a packet-level reference model.   |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_flash_pkt_streamer;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        pkt_done;
  logic [15:0] pkt_byte_num;
  logic        addr_load;
  logic [23:0] base_addr;
  logic        prog_start;
  logic [23:0] prog_addr;
  logic [8:0]  prog_len;
  logic        byte_req;
  logic [7:0]  byte_data;
  logic        prog_done;
  logic        busy;
  logic        overflow;
`ifdef FLASH_PKT_STREAMER_STAT_EN
  logic [15:0] pkt_cnt, drop_cnt;
`endif

  flash_pkt_streamer dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .pkt_done     (pkt_done),
    .pkt_byte_num (pkt_byte_num),
    .addr_load    (addr_load),
    .base_addr    (base_addr),
    .prog_start   (prog_start),
    .prog_addr    (prog_addr),
    .prog_len     (prog_len),
    .byte_req     (byte_req),
    .byte_data    (byte_data),
    .prog_done    (prog_done),
    .busy         (busy),
    .overflow     (overflow)
`ifdef FLASH_PKT_STREAMER_STAT_EN
    ,
    .pkt_cnt      (pkt_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int starts_seen = 0;

  // Reference model state
  logic [31:0] pw[$];
  logic [7:0]  eb[$];
  logic [23:0] ca[$];
  int          cl[$];
  logic [23:0] m_addr;
  bit          m_ovf;
  int          m_pkts, m_drops;

  // Count prog_start pulses, sampled away from the active edge
  always @(negedge sys_clk) if (prog_start === 1'b1) starts_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats();
`ifdef FLASH_PKT_STREAMER_STAT_EN
    check("pkt_cnt", {16'd0, pkt_cnt}, m_pkts);
    check("drop_cnt", {16'd0, drop_cnt}, m_drops);
`endif
  endtask

  // Packet-level model: byte stream MSB first, chunks never cross a page
  task automatic model_pkt(input int nw, input int bnum);
    int stored, len, r, l, room;
    logic [23:0] a;
    stored = (nw > 512) ? 512 : nw;
    if (nw > 512) begin
      m_ovf = 1'b1;
      m_drops += nw - 512;
    end
    len = (bnum < 4 * stored) ? bnum : 4 * stored;
    eb.delete(); ca.delete(); cl.delete();
    for (int k = 0; k < len; k++) eb.push_back(8'(pw[k / 4] >> (24 - 8 * (k % 4))));
    a = m_addr;
    r = len;
    while (r > 0) begin
      room = 256 - int'(a[7:0]);
      l = (r < room) ? r : room;
      ca.push_back(a);
      cl.push_back(l);
      a = a + 24'(l);
      r -= l;
    end
    m_addr = a;
    if (len > 0) m_pkts++;
  endtask

  task automatic send_pkt(input int bnum, input bit joined);
    int nw;
    nw = pw.size();
    for (int i = 0; i < nw; i++) begin
      @(negedge sys_clk);
      wr_en = 1'b1;
      wr_data = pw[i];
      if (joined && i == nw - 1) begin
        pkt_done = 1'b1;
        pkt_byte_num = 16'(bnum);
      end
    end
    @(negedge sys_clk);
    wr_en = 1'b0;
    if (!(joined && nw > 0)) begin
      pkt_done = 1'b1;
      pkt_byte_num = 16'(bnum);
      @(negedge sys_clk);
    end
    pkt_done = 1'b0;
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    while (prog_start !== 1'b1 && t < 40) begin
      @(negedge sys_clk);
      t++;
    end
    check("prog_start_seen", {31'd0, prog_start}, 1);
  endtask

  // One packet end to end, acting as the flash driver
  task automatic run_pkt(input logic [23:0] base, input bit load, input int bnum,
                         input bit joined, input bit inj);
    int nch, n0, gap;
    logic [7:0] last_b;
    if (load) begin
      @(negedge sys_clk);
      addr_load = 1'b1;
      base_addr = base;
      @(negedge sys_clk);
      addr_load = 1'b0;
      m_addr = base;
      m_ovf = 1'b0;
    end
    n0 = starts_seen;
    send_pkt(bnum, joined);
    model_pkt(pw.size(), bnum);
    nch = ca.size();
    last_b = 8'h00;
    for (int c = 0; c < nch; c++) begin
      wait_start();
      if (prog_start !== 1'b1) return;
      check("prog_addr", prog_addr, ca[c]);
      check("prog_len", prog_len, cl[c]);
      for (int i = 0; i < cl[c]; i++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge sys_clk);
        byte_req = 1'b1;
        @(negedge sys_clk);
        byte_req = 1'b0;
        last_b = eb.pop_front();
        check("byte_data", byte_data, last_b);
      end
      // A request past the chunk length must be ignored
      byte_req = 1'b1;
      @(negedge sys_clk);
      byte_req = 1'b0;
      check("byte_hold", byte_data, last_b);
      check("busy_wait", busy, 1);
      if (inj && c == 0) begin
        wr_en = 1'b1;
        @(negedge sys_clk);
        wr_en = 1'b0;
        m_ovf = 1'b1;
        m_drops++;
      end
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
      check("addr_stable", prog_addr, ca[c]);
      check("len_stable", prog_len, cl[c]);
      prog_done = 1'b1;
      @(negedge sys_clk);
      prog_done = 1'b0;
    end
    if (nch == 0) repeat (4) @(negedge sys_clk);
    check("busy_idle", busy, 0);
    check("overflow", overflow, m_ovf);
    check("start_count", starts_seen - n0, nch);
    check_stats();
  endtask

  task automatic check_reset_outputs();
    check("rst_prog_start", prog_start, 0);
    check("rst_prog_addr", prog_addr, 0);
    check("rst_prog_len", prog_len, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check_stats();
  endtask

  initial begin
    logic [23:0] rb;
    int nw, bn, mode;
    sys_rst = 1'b1;
    wr_en = 1'b0; wr_data = '0; pkt_done = 1'b0; pkt_byte_num = '0;
    addr_load = 1'b0; base_addr = '0; byte_req = 1'b0; prog_done = 1'b0;
    m_addr = '0; m_ovf = 1'b0; m_pkts = 0; m_drops = 0;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs();
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Test 1: 8-byte packet at address 0
    pw = '{32'h01020304, 32'h05060708};
    run_pkt(24'h000000, 1'b1, 8, 1'b0, 1'b0);

    // Test 2: page-crossing 6-byte packet
    pw = '{32'hA0A1A2A3, 32'hB0B1B2B3};
    run_pkt(24'h0000FC, 1'b1, 6, 1'b1, 1'b0);
    // Follow-on packet without reload continues at 0x000102
    pw = '{32'h11223344};
    run_pkt(24'h000000, 1'b0, 4, 1'b0, 1'b0);

    // Test 3: 600-byte packet from 0
    pw.delete();
    for (int i = 0; i < 150; i++) pw.push_back($urandom);
    run_pkt(24'h000000, 1'b1, 600, 1'b0, 1'b0);

    // Test 4: buffer overflow, 513 words
    pw.delete();
    for (int i = 0; i < 513; i++) pw.push_back($urandom);
    run_pkt(24'h000000, 1'b1, 2052, 1'b0, 1'b0);

    // Test 5: address wrap at the top of the flash
    pw = '{32'hCAFEBABE};
    run_pkt(24'hFFFFFE, 1'b1, 4, 1'b0, 1'b0);

    // Test 6: reset in the middle of a chunk
    @(negedge sys_clk);
    addr_load = 1'b1; base_addr = 24'h000040;
    @(negedge sys_clk);
    addr_load = 1'b0;
    pw = '{32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};
    send_pkt(16, 1'b0);
    wait_start();
    repeat (2) begin
      byte_req = 1'b1;
      @(negedge sys_clk);
    end
    byte_req = 1'b0;
    sys_rst = 1'b1;
    m_addr = '0; m_ovf = 1'b0; m_pkts = 0; m_drops = 0;
    @(negedge sys_clk);
    check_reset_outputs();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    pw = '{32'h55667788};
    run_pkt(24'h000000, 1'b0, 4, 1'b0, 1'b0);

    // Zero-length packet: nothing programmed, buffer discarded
    pw = '{32'hDEADBEEF, 32'h01234567};
    run_pkt(24'h000000, 1'b0, 0, 1'b0, 1'b0);

    // Randomised packets
    for (int p = 0; p < 14; p++) begin
      case ($urandom_range(0, 2))
        0:       rb = 24'($urandom);
        1:       rb = {16'($urandom), 8'($urandom_range(240, 255))};
        default: rb = {16'hFFFF, 8'($urandom_range(200, 255))};
      endcase
      nw = $urandom_range(0, 40);
      pw.delete();
      for (int i = 0; i < nw; i++) pw.push_back($urandom);
      mode = $urandom_range(0, 3);
      case (mode)
        0:       bn = 4 * nw;
        1:       bn = $urandom_range(0, 4 * nw);
        2:       bn = 4 * nw + $urandom_range(1, 20);
        default: bn = (nw == 0) ? 0 : 4 * nw - $urandom_range(1, 3);
      endcase
      run_pkt(rb, ($urandom_range(0, 2) != 0), bn, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
